// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single register-file write port between the
// writeback stage (priority) and a long-latency unit whose results wait in a
// small FIFO. A starvation counter steals one cycle from writeback so the
// FIFO head is eventually written.
module rf_wport_arbiter #(
    parameter int DW           = 64,
    parameter int AW           = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ws_valid,
    input  logic [AW+DW:0]           ws_to_rf_bus,
    output logic                     ws_hold,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [AW-1:0]            lu_waddr,
    input  logic [DW-1:0]            lu_wdata,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              drain_events
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t          state, state_next;
    logic [WCW-1:0]  wait_cnt, wait_next;
    logic            drain_inc;

    logic [AW-1:0]   mem_addr [DEPTH];
    logic [DW-1:0]   mem_data [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;

    logic            wb_we;
    logic [AW-1:0]   wb_waddr;
    logic [DW-1:0]   wb_wdata;
    logic            wb_req;
    logic            fifo_empty;
    logic            push, pop, grant_wb;

    assign wb_we      = ws_to_rf_bus[AW+DW];
    assign wb_waddr   = ws_to_rf_bus[AW+DW-1:DW];
    assign wb_wdata   = ws_to_rf_bus[DW-1:0];
    assign wb_req     = ws_valid && wb_we && (wb_waddr != '0);
    assign fifo_empty = (count == '0);

    // Ready comes from the registered occupancy only; a same-cycle pop never frees a slot early.
    assign lu_ready   = reset && (count < CW'(DEPTH));
    assign push       = lu_valid && lu_ready && (lu_waddr != '0);
    assign pop        = !fifo_empty && ((state == S_DRAIN) || !wb_req);
    assign grant_wb   = wb_req && (state != S_DRAIN);
    assign count_next = count + CW'(push) - CW'(pop);

    assign ws_hold      = (state == S_DRAIN);
    assign fifo_count   = count;

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= lu_waddr;
            mem_data[wr_ptr] <= lu_wdata;
        end
    end

    // Starvation FSM state, wait counter and saturating forced-drain counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            drain_events <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (drain_inc && (drain_events != 16'hFFFF))
                drain_events <= drain_events + 16'd1;
        end
    end

    // Next-state logic: count lost arbitration cycles of a non-empty FIFO, force one drain cycle at the limit.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        drain_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (push) begin
                    state_next = S_WAIT;
                    wait_next  = '0;
                end
            end
            S_WAIT: begin
                if (pop) begin
                    wait_next  = '0;
                    state_next = (count_next == '0) ? S_IDLE : S_WAIT;
                end else if (wait_cnt == WAIT_MAX) begin
                    wait_next  = '0;
                    state_next = S_DRAIN;
                end else begin
                    wait_next  = wait_cnt + WCW'(1);
                end
            end
            S_DRAIN: begin
                wait_next  = '0;
                drain_inc  = 1'b1;
                state_next = (count_next != '0) ? S_WAIT : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                wait_next  = '0;
            end
        endcase
    end

    // Registered write port: the granted write appears one cycle later; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_wb || pop;
            if (grant_wb) begin
                rf_waddr <= wb_waddr;
                rf_wdata <= wb_wdata;
            end else if (pop) begin
                rf_waddr <= mem_addr[rd_ptr];
                rf_wdata <= mem_data[rd_ptr];
            end
        end
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the writeback stage and a long-latency unit (LLU: mul/div, late load return).
- Writeback has priority. LLU results queue in a small FIFO.
- A starvation counter forces a drain slot by holding writeback for one cycle.
- Sits between the writeback stage bus / LLU result port and the regfile write port.

Parameters:
- DW, 64, data width of writeback and LLU results.
- AW, 5, register address width.
- DEPTH, 2, LLU result FIFO entries; power of two, >=2.
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before a forced drain; >=1.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- ws_valid  in  1  writeback stage holds a valid instruction this cycle.
- ws_to_rf_bus  in  70  {we[69], waddr[68:64], wdata[63:0]} from writeback.
- ws_hold  out  1  1 = writeback must not retire this cycle (gates ws_allowin / retire).
- lu_valid  in  1  LLU result valid.
- lu_ready  out  1  FIFO can accept an LLU result.
- lu_waddr  in  AW  LLU destination register.
- lu_wdata  in  DW  LLU result data.
- rf_we  out  1  regfile write enable (registered).
- rf_waddr  out  AW  regfile write address (registered).
- rf_wdata  out  DW  regfile write data (registered).
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- drain_events  out  16  saturating count of forced-drain cycles.

Behaviour:
- Reset (reset==0 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO emptied, fifo_count=0, wait_cnt=0, state=IDLE.
  - ws_hold=0, drain_events=0.
  - lu_ready=0 while reset is low.
  - Reset mid-operation discards all queued LLU results; no write is issued afterwards.
- WB request: ws_valid & we & (waddr!=0). Writes to r0 are never requests; the port is free that cycle.
- LLU push:
  - lu_valid & lu_ready completes a handshake.
  - Pushed only if lu_waddr!=0; r0 results are accepted and silently dropped.
- lu_ready = (fifo_count < DEPTH). Based on registered count; no same-cycle pop passthrough.
- Grant, combinational each cycle:
  - state==DRAIN: grant FIFO head; WB not granted.
  - else WB request: grant WB.
  - else FIFO non-empty: grant FIFO head (pop).
  - else: no grant.
- Output register: the granted write appears on rf_we/rf_waddr/rf_wdata the next cycle; latency 1. No grant -> rf_we=0 next cycle, addr/data hold previous values.
- FSM (Moore; ws_hold = (state==DRAIN)):
  - IDLE: FIFO empty. Push -> WAIT, wait_cnt=0.
  - WAIT: FIFO non-empty.
    - Head granted: wait_cnt=0; go IDLE if count after pop/push is 0, else stay.
    - Head not granted: wait_cnt+1; if wait_cnt==STARVE_LIMIT-1 -> DRAIN.
  - DRAIN: lasts exactly one cycle, head popped.
    - Next state WAIT (wait_cnt=0) if count after pop/push >0, else IDLE.
    - drain_events += 1, saturating at 16'hFFFF.
- Push and pop in the same cycle: count unchanged; FIFO order preserved; wrap-around of read/write pointers is modulo DEPTH.
- Ordering between WB and LLU writes to the same register is not guaranteed by this block. The upstream scoreboard prevents WAW overlap.

Test Plan:
- Reset held 2 cycles, then released; no inputs -> rf_we=0, ws_hold=0, fifo_count=0, lu_ready=1 after release, 0 during reset.
- ws_valid=1, ws_to_rf_bus={1,5'd2,64'd20}, one cycle -> next cycle rf_we=1, rf_waddr=2, rf_wdata=20.
- ws_to_rf_bus={1,5'd0,64'd7}; LLU pushes {5'd3,64'h55} the same cycle -> r0 write suppressed; next cycle head granted, rf_we=1 with waddr=3, data=64'h55 one cycle after that; fifo_count returns 0.
- STARVE_LIMIT=4; continuous WB writes {1,5'd4,i}; one LLU push {5'd9,64'hAB} -> after 4 lost cycles ws_hold=1 for exactly one cycle; next cycle rf_waddr=9, rf_wdata=64'hAB; drain_events=1.
- Fill FIFO with 2 LLU results under continuous WB -> lu_ready=0 at count=2; third lu_valid stalls until a pop. Results emerge in push order.
- Reset asserted with 2 queued entries -> FIFO cleared; after release no rf_we=1 occurs without new requests.
